mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: cycles a granted access may wait for mem_ack_i before it is aborted with error.
REQ-002 Parameter AW, default 64: address width.
REQ-003 Parameter DW, default 64: data width.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n_i  in  1  synchronous, active-low reset.
REQ-006 f_req_i / f_addr_i  in  1 / AW  fetch-stage read request and address.
REQ-007 f_rdata_o / f_ack_o / f_err_o / f_stall_o  out  DW / 1 / 1 / 1  fetch read data, completion pulse, error flag, stall to the pipeline controller.
REQ-008 m_req_i / m_we_i / m_addr_i / m_wdata_i  in  1 / 1 / AW / DW  memory-stage request, write enable, address, write data.
REQ-009 m_rdata_o / m_ack_o / m_err_o / m_stall_o  out  DW / 1 / 1 / 1  memory-stage read data, completion pulse, error flag, stall.
REQ-010 mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o  out  1 / 1 / AW / DW  request to the single-port unified memory.
REQ-011 mem_rdata_i / mem_ack_i  in  DW / 1  memory read data and completion strobe.

Function
REQ-012 States: IDLE, F_BUSY, D_BUSY; a 2-bit registered state.
REQ-013 IDLE with m_req_i=1: next state D_BUSY; else f_req_i=1: F_BUSY; else stay IDLE (fixed data priority, build without REQ-030).
REQ-014 On entering a BUSY state, the granted port's address, write enable and write data are latched; mem_* outputs drive latched values only.
REQ-015 mem_req_o = 1 exactly while in F_BUSY or D_BUSY; mem_we_o = 0 in F_BUSY.
REQ-016 Latency: mem_req_o rises one cycle after the winning request is first sampled in IDLE.
REQ-017 In a BUSY state with mem_ack_i=1: pulse the granted port's ack for that same cycle, pass mem_rdata_i to its rdata (0 on writes), err=0, next state IDLE.
REQ-018 Back-to-back: a request still pending in IDLE after a completion is granted the next cycle; minimum one idle cycle between memory accesses.
REQ-019 Timeout counter clears on BUSY entry and increments each BUSY cycle without ack; at count TIMEOUT_CYCLES-1 without ack, pulse the granted port's ack with err=1, rdata=0, next state IDLE.
REQ-020 mem_ack_i in the timeout cycle takes precedence: normal completion, err=0.
REQ-021 mem_ack_i while IDLE is ignored; no port ack.
REQ-022 f_stall_o = f_req_i & ~f_ack_o; m_stall_o = m_req_i & ~m_ack_o (combinational).
REQ-023 Requester dropping its request mid-access: the transaction completes on the memory side; the ack pulse is still issued and the requester ignores it.
REQ-024 Ungranted port's ack, err, rdata are 0 in every cycle.
REQ-025 Every err pulse (f_err_o or m_err_o) is reported as an address error (SADR) by the status logic downstream.

Reset
REQ-026 While rst_n_i=0 at a clock edge: state to IDLE, counter to 0, latched address/data to 0, priority pointer to "fetch last".
REQ-027 After reset all outputs are 0; mem_req_o falls the cycle after reset is sampled, even mid-access.
REQ-028 An ack arriving after a mid-access reset is ignored per REQ-021.

Configuration
REQ-029 Macro Y86_ARB_RR_EN selects the arbitration policy.
REQ-030 Defined: round-robin; when both request in IDLE, the port not granted last wins; last-granted pointer updates on every grant.
REQ-031 Undefined: fixed data priority per REQ-013; no pointer register exists.

Structure
REQ-032 State encodings (IDLE/F_BUSY/D_BUSY) and the SADR status code belong in the shared define file/package alongside the pipeline status codes.
REQ-033 Timeout counter is one sub-module, arb_timeout_cnt (clear, enable, expire output); everything else in mem_arbiter.

Verification
REQ-034 f_req only, addr 0x100, ack after 3 cycles with rdata 0x30F4 -> mem_req_o high 3 cycles, f_ack_o one pulse with f_rdata_o=0x30F4, f_err_o=0.
REQ-035 f_req and m_req (write 0x200, data 0xAB) same cycle, no RR -> D_BUSY first with mem_we_o=1; after ack, F_BUSY next cycle; f_stall_o high throughout.
REQ-036 Same as REQ-035 with Y86_ARB_RR_EN, two consecutive contention rounds -> grants D, F, D, F.
REQ-037 m_req read, no ack, TIMEOUT_CYCLES=16 -> m_ack_o and m_err_o pulse 16 cycles after mem_req_o rises; state IDLE.
REQ-038 rst_n_i low during D_BUSY, then ack -> mem_req_o low next cycle, no m_ack_o pulse, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_pkg : arbiter state encodings and pipeline status    |
// | codes.  Rev 1.0                                                  |
// +------------------------------------------------------------------+
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_F_BUSY = 2'd1,
      ARB_D_BUSY = 2'd2
   } arb_state_t;

   // Pipeline status codes; an arbiter error is reported as SADR.
   typedef enum logic [2:0] {
      STAT_AOK  = 3'd1,
      STAT_HLT  = 3'd2,
      STAT_SADR = 3'd3,
      STAT_INS  = 3'd4
   } stat_t;

   function automatic stat_t arb_err_stat(input logic err);
      return err ? STAT_SADR : STAT_AOK;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_if : fetch, memory-stage and unified-memory buses    |
// | around the arbiter.  Rev 1.0                                     |
// +------------------------------------------------------------------+
interface mem_arbiter_if #(
   parameter int AW = 64,
   parameter int DW = 64
);
   logic          f_req_i;
   logic [AW-1:0] f_addr_i;
   logic [DW-1:0] f_rdata_o;
   logic          f_ack_o;
   logic          f_err_o;
   logic          f_stall_o;

   logic          m_req_i;
   logic          m_we_i;
   logic [AW-1:0] m_addr_i;
   logic [DW-1:0] m_wdata_i;
   logic [DW-1:0] m_rdata_o;
   logic          m_ack_o;
   logic          m_err_o;
   logic          m_stall_o;

   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;
   logic          mem_ack_i;

   modport slave (
      input  f_req_i, f_addr_i,
      output f_rdata_o, f_ack_o, f_err_o, f_stall_o,
      input  m_req_i, m_we_i, m_addr_i, m_wdata_i,
      output m_rdata_o, m_ack_o, m_err_o, m_stall_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i
   );

   modport master (
      output f_req_i, f_addr_i,
      input  f_rdata_o, f_ack_o, f_err_o, f_stall_o,
      output m_req_i, m_we_i, m_addr_i, m_wdata_i,
      input  m_rdata_o, m_ack_o, m_err_o, m_stall_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_timeout_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arb_timeout_cnt : counts busy cycles without ack and flags the   |
// | last allowed one.  Rev 1.0                                       |
// +------------------------------------------------------------------+
module arb_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign expire = (r_count == LIMIT);
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : shares one unified memory port between fetch and   |
// | memory stages with timeout. Macro Y86_ARB_RR_EN = round-robin.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int AW             = 64,
   parameter int DW             = 64
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   mem_arbiter_if.slave   bus
);
   arb_state_t    r_state;
   arb_state_t    w_next;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic          r_we;
   logic          w_grant_f;
   logic          w_grant_d;
   logic          w_f_done;
   logic          w_d_done;
   logic          w_pick_d;
   logic          w_busy;
   logic          w_expire;

   assign w_busy = (r_state != ARB_IDLE);

`ifdef Y86_ARB_RR_EN
   logic r_last_f;

   // On contention the port that was not granted last wins.
   assign w_pick_d = bus.m_req_i & (~bus.f_req_i | r_last_f);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_last_f <= 1'b1;
      end else if (w_grant_d) begin
         r_last_f <= 1'b0;
      end else if (w_grant_f) begin
         r_last_f <= 1'b1;
      end
   end
`else
   assign w_pick_d = bus.m_req_i;
`endif

   arb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clear   (~w_busy),
      .enable  (w_busy & ~bus.mem_ack_i),
      .expire  (w_expire)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_grant_f = 1'b0;
      w_grant_d = 1'b0;
      w_f_done  = 1'b0;
      w_d_done  = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_d) begin
               w_next    = ARB_D_BUSY;
               w_grant_d = 1'b1;
            end else if (bus.f_req_i) begin
               w_next    = ARB_F_BUSY;
               w_grant_f = 1'b1;
            end
         end
         ARB_F_BUSY: begin
            w_f_done = bus.mem_ack_i | w_expire;
            if (w_f_done) w_next = ARB_IDLE;
         end
         ARB_D_BUSY: begin
            w_d_done = bus.mem_ack_i | w_expire;
            if (w_d_done) w_next = ARB_IDLE;
         end
         default: w_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
      end else if (w_grant_d) begin
         r_addr  <= bus.m_addr_i;
         r_wdata <= bus.m_wdata_i;
         r_we    <= bus.m_we_i;
      end else if (w_grant_f) begin
         r_addr  <= bus.f_addr_i;
         r_wdata <= '0;
         r_we    <= 1'b0;
      end
   end

   // An ack in the expiry cycle wins, so err is only raised without ack.
   assign bus.f_ack_o   = w_f_done;
   assign bus.f_err_o   = w_f_done & ~bus.mem_ack_i;
   assign bus.f_rdata_o = (w_f_done & bus.mem_ack_i) ? bus.mem_rdata_i : '0;
   assign bus.f_stall_o = bus.f_req_i & ~w_f_done;

   assign bus.m_ack_o   = w_d_done;
   assign bus.m_err_o   = w_d_done & ~bus.mem_ack_i;
   assign bus.m_rdata_o = (w_d_done & bus.mem_ack_i & ~r_we) ? bus.mem_rdata_i : '0;
   assign bus.m_stall_o = bus.m_req_i & ~w_d_done;

   assign bus.mem_req_o   = w_busy;
   assign bus.mem_we_o    = r_we & (r_state == ARB_D_BUSY);
   assign bus.mem_addr_o  = r_addr;
   assign bus.mem_wdata_o = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter : directed and random transactions against a      |
// | transaction-level model of the arbiter.  Rev 1.0                 |
// +------------------------------------------------------------------+
module tb_mem_arbiter;
   localparam int T  = 16;
   localparam int AW = 64;
   localparam int DW = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   last_f  = 1'b1;

   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_arbiter #(
      .TIMEOUT_CYCLES (T),
      .AW             (AW),
      .DW             (DW)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus.slave)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd();
      return {$urandom(), $urandom()};
   endfunction

   task automatic all_zero(input string tag);
      chk({tag, "_mem_req"}, bus.mem_req_o, 0);
      chk({tag, "_mem_we"}, bus.mem_we_o, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr_o, 0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata_o, 0);
      chk({tag, "_f_ack"}, bus.f_ack_o, 0);
      chk({tag, "_f_err"}, bus.f_err_o, 0);
      chk({tag, "_f_rdata"}, bus.f_rdata_o, 0);
      chk({tag, "_f_stall"}, bus.f_stall_o, 0);
      chk({tag, "_m_ack"}, bus.m_ack_o, 0);
      chk({tag, "_m_err"}, bus.m_err_o, 0);
      chk({tag, "_m_rdata"}, bus.m_rdata_o, 0);
      chk({tag, "_m_stall"}, bus.m_stall_o, 0);
   endtask

   // One access from the idle cycle in which requests are sampled to completion.
   // delay = busy cycle carrying the ack (0 = never).
   task automatic serve(input int delay, input logic [DW-1:0] rdv, input bit drop_mid);
      bit            is_d;
      bit            err;
      bit            fin;
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wd;
      logic [DW-1:0] exp_rd;
      int            endc;
      if (bus.m_req_i && bus.f_req_i) begin
`ifdef Y86_ARB_RR_EN
         is_d = last_f;
`else
         is_d = 1'b1;
`endif
      end else begin
         is_d = bus.m_req_i;
      end
      last_f   = !is_d;
      exp_we   = is_d ? bus.m_we_i : 1'b0;
      exp_addr = is_d ? bus.m_addr_i : bus.f_addr_i;
      exp_wd   = is_d ? bus.m_wdata_i : '0;
      err      = !(delay >= 1 && delay <= T);
      endc     = err ? T : delay;
      exp_rd   = (err || exp_we) ? '0 : rdv;

      bus.mem_ack_i   = 1'($urandom_range(0, 1));
      bus.mem_rdata_i = rnd();
      @(negedge clk);
      chk("idle_mem_req", bus.mem_req_o, 0);
      chk("idle_f_ack", bus.f_ack_o, 0);
      chk("idle_m_ack", bus.m_ack_o, 0);
      step();
      for (int c = 1; c <= endc; c++) begin
         bus.mem_ack_i   = (c == delay);
         bus.mem_rdata_i = (c == delay) ? rdv : rnd();
         if (drop_mid && c == 2) begin
            if (is_d) bus.m_req_i = 1'b0;
            else      bus.f_req_i = 1'b0;
         end
         fin = (c == endc);
         @(negedge clk);
         chk("mem_req", bus.mem_req_o, 1);
         chk("mem_we", bus.mem_we_o, exp_we);
         chk("mem_addr", bus.mem_addr_o, exp_addr);
         chk("mem_wdata", bus.mem_wdata_o, exp_wd);
         chk("f_ack", bus.f_ack_o, fin && !is_d);
         chk("m_ack", bus.m_ack_o, fin && is_d);
         chk("f_err", bus.f_err_o, fin && !is_d && err);
         chk("m_err", bus.m_err_o, fin && is_d && err);
         chk("f_rdata", bus.f_rdata_o, (fin && !is_d) ? exp_rd : '0);
         chk("m_rdata", bus.m_rdata_o, (fin && is_d) ? exp_rd : '0);
         chk("f_stall", bus.f_stall_o, bus.f_req_i && !(fin && !is_d));
         chk("m_stall", bus.m_stall_o, bus.m_req_i && !(fin && is_d));
         step();
      end
      bus.mem_ack_i = 1'b0;
      if (is_d) bus.m_req_i = 1'b0;
      else      bus.f_req_i = 1'b0;
   endtask

   task automatic raise_f();
      bus.f_req_i  = 1'b1;
      bus.f_addr_i = rnd();
   endtask

   task automatic raise_m();
      bus.m_req_i   = 1'b1;
      bus.m_we_i    = 1'($urandom_range(0, 1));
      bus.m_addr_i  = rnd();
      bus.m_wdata_i = rnd();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      int sel;
      bus.f_req_i = 0; bus.f_addr_i = '0;
      bus.m_req_i = 0; bus.m_we_i = 0; bus.m_addr_i = '0; bus.m_wdata_i = '0;
      bus.mem_ack_i = 0; bus.mem_rdata_i = '0;

      rst_n = 1'b0;
      repeat (3) step();
      @(negedge clk);
      all_zero("reset");
      step();
      rst_n = 1'b1;

      // Single fetch read, ack in third busy cycle.
      bus.f_req_i = 1'b1; bus.f_addr_i = 64'h100;
      serve(3, 64'h30F4, 1'b0);

      // Contention: data write first, pending fetch next (two rounds).
      for (int r = 0; r < 2; r++) begin
         bus.f_req_i = 1'b1; bus.f_addr_i = 64'h300 + 64'(r);
         bus.m_req_i = 1'b1; bus.m_we_i = 1'b1;
         bus.m_addr_i = 64'h200; bus.m_wdata_i = 64'hAB;
         serve(2, 64'hDEAD, 1'b0);
         serve(4, 64'h1234, 1'b0);
      end

      // Memory-stage read with no ack ever: timeout.
      bus.m_req_i = 1'b1; bus.m_we_i = 1'b0; bus.m_addr_i = 64'h40;
      serve(0, 64'h0, 1'b0);

      // Ack exactly on the expiry cycle completes normally.
      bus.m_req_i = 1'b1; bus.m_we_i = 1'b0; bus.m_addr_i = 64'h48;
      serve(T, 64'h5A5A, 1'b0);

      // Reset during a data access, then a late ack.
      bus.m_req_i = 1'b1; bus.m_we_i = 1'b0; bus.m_addr_i = 64'h440;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("rst_mid_busy_mem_req", bus.mem_req_o, 1);
      step();
      rst_n = 1'b0;
      bus.m_req_i = 1'b0;
      step();
      rst_n = 1'b1;
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 64'h77;
      @(negedge clk);
      all_zero("rst_mid");
      step();
      bus.mem_ack_i = 1'b0;
      last_f = 1'b1;

      for (int it = 0; it < 60; it++) begin
         if (!bus.f_req_i && !bus.m_req_i) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               bus.mem_ack_i   = 1'($urandom_range(0, 1));
               bus.mem_rdata_i = rnd();
               @(negedge clk);
               chk("gap_mem_req", bus.mem_req_o, 0);
               chk("gap_f_ack", bus.f_ack_o, 0);
               chk("gap_m_ack", bus.m_ack_o, 0);
               chk("gap_f_rdata", bus.f_rdata_o, 0);
               chk("gap_m_rdata", bus.m_rdata_o, 0);
               step();
            end
            bus.mem_ack_i = 1'b0;
            sel = $urandom_range(1, 3);
            if (sel[0]) raise_f();
            if (sel[1]) raise_m();
         end else if ($urandom_range(0, 1) == 1) begin
            if (!bus.f_req_i) raise_f();
            else if (!bus.m_req_i) raise_m();
         end
         serve($urandom_range(0, T + 2), rnd(), $urandom_range(0, 3) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
